// File: rtl/wb_pkg.sv
// Shared types for the write-back stage.
//   reg_addr_t : register file address (5 bits)
//   word_t     : register file data word (32 bits)
//   wb_req_t   : one pending register write {addr, data}
//   REG_ZERO   : hard-wired zero register; writes to it are dropped
package wb_pkg;

   typedef logic [4:0]  reg_addr_t;
   typedef logic [31:0] word_t;

   typedef struct packed {
      reg_addr_t addr;
      word_t     data;
   } wb_req_t;

   localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_req_t used to buffer MDU results.
// Ports:
//   clk, rst      : clock, asynchronous active-low reset (empties the FIFO)
//   push, din     : store din at the clock edge (ignored when full unless
//                   a pop happens in the same cycle)
//   pop, dout     : dout is the current head; pop removes it at the edge
//   full, empty   : occupancy flags
// Pointers carry one extra wrap bit: equal pointers mean empty, pointers
// differing only in the wrap bit mean full.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic    clk,
   input  logic    rst,
   input  logic    push,
   input  logic    pop,
   input  wb_req_t din,
   output wb_req_t dout,
   output logic    full,
   output logic    empty
);

   localparam int AW = $clog2(DEPTH);

   logic [AW:0] wptr_q, wptr_d;
   logic [AW:0] rptr_q, rptr_d;
   wb_req_t     mem_q [DEPTH];
   logic        do_push;
   logic        do_pop;

   assign empty = (wptr_q == rptr_q);
   assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                  (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
   assign dout  = mem_q[rptr_q[AW-1:0]];

   // When full, a push is still taken if the head leaves in the same cycle:
   // the write lands in the slot being vacated, occupancy is unchanged.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (do_push) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
      if (do_pop)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wptr_q <= '0;
         rptr_q <= '0;
      end else begin
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
      end
   end

   // Storage needs no reset: the pointers alone define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wptr_q[AW-1:0]] <= din;
   end

endmodule

// File: rtl/writeback_arbiter.sv
// Write-back arbiter in front of the single register file write port.
// Merges in-order pipeline results with buffered MDU results, stalls the
// pipeline when the MDU FIFO head has waited too long, and keeps a
// per-register scoreboard of destinations still awaiting an MDU result.
// Ports:
//   clk, rst                          : clock, async active-low reset
//   pipe_wen/waddr/wdata, pipe_stall  : pipeline write; hold while stalled
//   mdu_valid/waddr/wdata, mdu_ready  : MDU result push (ready = !full)
//   issue_valid/waddr, issue_ready    : mark an MDU destination busy
//   raddr_a/busy_a, raddr_b/busy_b    : combinational scoreboard reads
//   wen/waddr/wdata                   : registered register file write
// Handshake: an MDU push happens when mdu_valid && mdu_ready, or when the
// FIFO is full and its head leaves in the same cycle.
module writeback_arbiter
   import wb_pkg::*;
#(
   parameter int DEPTH        = 4,
   parameter int STARVE_LIMIT = 3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_wen,
   input  logic [4:0]  pipe_waddr,
   input  logic [31:0] pipe_wdata,
   output logic        pipe_stall,
   input  logic        mdu_valid,
   output logic        mdu_ready,
   input  logic [4:0]  mdu_waddr,
   input  logic [31:0] mdu_wdata,
   input  logic        issue_valid,
   input  logic [4:0]  issue_waddr,
   output logic        issue_ready,
   input  logic [4:0]  raddr_a,
   output logic        busy_a,
   input  logic [4:0]  raddr_b,
   output logic        busy_b,
   output logic        wen,
   output logic [4:0]  waddr,
   output logic [31:0] wdata
);

   localparam int             CW    = $clog2(STARVE_LIMIT + 1);
   localparam logic [CW-1:0]  LIMIT = CW'(STARVE_LIMIT);

   logic          wen_q, wen_d;
   reg_addr_t     waddr_q, waddr_d;
   word_t         wdata_q, wdata_d;
   logic          stall_q, stall_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [31:0]   busy_q, busy_d;

   wb_req_t       fifo_din;
   wb_req_t       fifo_dout;
   logic          fifo_full;
   logic          fifo_empty;
   logic          pop;
   logic          pipe_acc;
   wb_req_t       sel;
   logic          sel_valid;

   assign fifo_din = '{addr: mdu_waddr, data: mdu_wdata};

   wb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (mdu_valid),
      .pop   (pop),
      .din   (fifo_din),
      .dout  (fifo_dout),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign mdu_ready   = !fifo_full;
   assign pipe_stall  = stall_q;
   assign issue_ready = !busy_q[issue_waddr];
   assign busy_a      = busy_q[raddr_a];
   assign busy_b      = busy_q[raddr_b];
   assign wen         = wen_q;
   assign waddr       = waddr_q;
   assign wdata       = wdata_q;

   always_comb begin
      pipe_acc  = pipe_wen && !stall_q;
      // A stalled cycle always has a non-empty FIFO, so the head wins it.
      pop       = !fifo_empty && (stall_q || !pipe_wen);
      sel       = '0;
      sel_valid = 1'b0;
      wen_d     = 1'b0;
      waddr_d   = waddr_q;
      wdata_d   = wdata_q;
      busy_d    = busy_q;
      cnt_d     = cnt_q;
      stall_d   = stall_q;

      if (pop) begin
         sel       = fifo_dout;
         sel_valid = 1'b1;
      end else if (pipe_acc) begin
         sel       = '{addr: pipe_waddr, data: pipe_wdata};
         sel_valid = 1'b1;
      end

      // r0 writes are consumed but never reach the register file.
      if (sel_valid && sel.addr != REG_ZERO) begin
         wen_d   = 1'b1;
         waddr_d = sel.addr;
         wdata_d = sel.data;
      end

      if (issue_valid && issue_ready && issue_waddr != REG_ZERO)
         busy_d[issue_waddr] = 1'b1;
      if (pop && fifo_dout.addr != REG_ZERO)
         busy_d[fifo_dout.addr] = 1'b0;

      if (fifo_empty || pop)
         cnt_d = '0;
      else if (cnt_q != LIMIT)
         cnt_d = cnt_q + CW'(1);

      stall_d = pop ? 1'b0 : (stall_q || (cnt_d == LIMIT));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wen_q   <= 1'b0;
         waddr_q <= '0;
         wdata_q <= '0;
         stall_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= '0;
      end else begin
         wen_q   <= wen_d;
         waddr_q <= waddr_d;
         wdata_q <= wdata_d;
         stall_q <= stall_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
      end
   end

endmodule
